// File: rtl/handshake_pkg.sv
// ============================================================================
// Module      : handshake_pkg
// Description : Shared constants for the 4-phase req/ack source block:
//               FSM state encoding, state width and synchronizer depth floor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package handshake_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_SETUP  = 2'd1;
   localparam logic [STATE_W-1:0] ST_REQ_HI = 2'd2;
   localparam logic [STATE_W-1:0] ST_REQ_LO = 2'd3;

   // Fewer than two flops gives no metastability settling time at all.
   localparam int MIN_SYNC_STAGES = 2;

endpackage : handshake_pkg

`default_nettype wire

// File: rtl/ack_sync_chain.sv
// ============================================================================
// Module      : ack_sync_chain
// Description : Multi-flop synchronizer for a single asynchronous level,
//               cleared asynchronously by an active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ack_sync_chain
   import handshake_pkg::*;
#(
   parameter int STAGES = 2
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   // Depths below the floor are silently raised so the chain is always safe.
   localparam int C_STAGES = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

   logic [C_STAGES-1:0] r_chain;

   // Shift the raw level through the chain; bit 0 is the metastable capture flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[C_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[C_STAGES-1];

endmodule : ack_sync_chain

`default_nettype wire

// File: rtl/handshake_tx.sv
// ============================================================================
// Module      : handshake_tx
// Description : Source side of a 4-phase req/ack bundled-data crossing.
//               Accepts words by valid/ready, holds them on data_out and
//               runs req_out against a synchronized copy of ack_in.
//               Optional phase timeout enabled by HANDSHAKE_TX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_tx
   import handshake_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             req_out,
   input  logic             ack_in,
   output logic             busy,
   output logic             timeout_err
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;
   logic [WIDTH-1:0]   r_data;
   logic               r_req;
   logic               w_ack_s;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_timeout;

   // Only the synchronized acknowledge is ever looked at by the FSM.
   ack_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (ack_in),
      .o_q   (w_ack_s)
   );

   // A stale high ack (e.g. left over from before reset) blocks new words.
   assign w_in_ready = (r_state == ST_IDLE) && !w_ack_s;
   assign w_accept   = in_valid && w_in_ready;

`ifdef HANDSHAKE_TX_TIMEOUT_EN
   localparam int C_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [C_CNT_W-1:0] r_cnt;
   logic               w_phase_wait;

   // Still waiting for the ack level this phase expects.
   assign w_phase_wait = ((r_state == ST_REQ_HI) && !w_ack_s) ||
                         ((r_state == ST_REQ_LO) &&  w_ack_s);
   assign w_timeout    = w_phase_wait && (r_cnt == C_CNT_LAST);

   // Phase counter: restarts on every state change, counts only while waiting on ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_cnt <= '0;
      end else if ((r_state == ST_REQ_HI) || (r_state == ST_REQ_LO)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   logic w_unused_timeout_cfg;

   assign w_timeout            = 1'b0;
   assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // Next-state decode; ack glitches against the expected level are simply ignored.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_REQ_HI;
         end
         ST_REQ_HI: begin
            if (w_ack_s) begin
               w_state_nxt = ST_REQ_LO;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ_LO: begin
            if (!w_ack_s) begin
               w_state_nxt = ST_IDLE;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Data is captured only on accept, so it is frozen for the whole handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (w_accept) begin
         r_data <= in_data;
      end
   end

   // Request is a straight flop of "next state is REQ_HI", so it cannot glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req <= 1'b0;
      end else begin
         r_req <= (w_state_nxt == ST_REQ_HI);
      end
   end

   assign in_ready    = w_in_ready;
   assign data_out    = r_data;
   assign req_out     = r_req;
   assign busy        = (r_state != ST_IDLE);
   assign timeout_err = w_timeout;

endmodule : handshake_tx

`default_nettype wire
